store_buffer: RTL and testbench

- Sits between the load/store execution unit and data memory, directly downstream of the reorder buffer's store-commit output.
- Holds executed stores in program order as speculative entries.
- Each stcommit pulse from the reorder buffer marks the oldest speculative entry as committed.
- Committed entries are drained to data memory one at a time over a valid/ack handshake. prmiss discards all speculative entries; committed entries always drain.

---
 rtl/store_buffer_if.sv | 46 ++++
 rtl/store_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Bundles the signals around the store buffer. These are the
//                store-issue port, the commit/flush controls from the
//                reorder buffer, the memory drain handshake and the load
//                forwarding probe.
//                The slave modport is the store buffer's view. The master
//                modport is the surrounding pipeline/memory view.
//  Ports       : st_we/st_addr/st_data   executed stores, program order
//                sb_full/sb_empty        occupancy flags
//                stcommit/prmiss         commit oldest speculative / flush
//                mem_we/mem_addr/mem_data/mem_ack  drain handshake
//                ld_addr/ld_hit/ld_data  load forwarding probe
//  Revision    : 1.0  initial release
// ============================================================================
interface store_buffer_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                st_we;
    logic [ADDR_LEN-1:0] st_addr;
    logic [DATA_LEN-1:0] st_data;
    logic                sb_full;
    logic                sb_empty;
    logic                stcommit;
    logic                prmiss;
    logic                mem_we;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_data;
    logic                mem_ack;
    logic [ADDR_LEN-1:0] ld_addr;
    logic                ld_hit;
    logic [DATA_LEN-1:0] ld_data;

    modport master (
        output st_we, st_addr, st_data, stcommit, prmiss, mem_ack, ld_addr,
        input  sb_full, sb_empty, mem_we, mem_addr, mem_data, ld_hit, ld_data
    );

    modport slave (
        input  st_we, st_addr, st_data, stcommit, prmiss, mem_ack, ld_addr,
        output sb_full, sb_empty, mem_we, mem_addr, mem_data, ld_hit, ld_data
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order store buffer between the load/store unit and data
//                memory. Executed stores enter as speculative entries. Each
//                stcommit marks the oldest speculative entry committed.
//                Committed entries drain to memory one at a time over a
//                valid/ack handshake. prmiss discards all speculative
//                entries, and committed entries always drain.
//  Ports       : clk    clock, rising edge
//                reset  asynchronous, active-low reset
//                sb     store_buffer_if.slave (store, commit, drain, load)
//  Options     : STORE_BUFFER_FWD_EN defined   -> store-to-load forwarding
//                                               from the youngest match
//                STORE_BUFFER_FWD_EN undefined -> ld_hit/ld_data tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int SB_SEL   = 2,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);

    localparam int                 c_cnt_w    = SB_SEL + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(SB_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_LEN-1:0] r_addr [SB_DEPTH];
    logic [DATA_LEN-1:0] r_data [SB_DEPTH];
    logic [SB_SEL-1:0]   r_head;
    logic [SB_SEL-1:0]   r_tail;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  r_ccnt;
    state_t              r_state;

    state_t              w_state_next;
    logic                w_mem_we;
    logic                w_full;
    logic                w_push;
    logic                w_commit;
    logic                w_pop;
    logic [SB_SEL-1:0]   w_head_next;
    logic [SB_SEL-1:0]   w_tail_next;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_cnt_w-1:0]  w_ccnt_next;

    // ------------------------------------------------------------------
    // Flags and event qualification
    // ------------------------------------------------------------------
    assign w_full      = (r_cnt == c_full_cnt);
    assign sb.sb_full  = w_full;
    assign sb.sb_empty = (r_cnt == '0);

    // Fullness is judged on the registered count, so a slot freed by a
    // same-cycle pop only becomes usable in the following cycle.
    assign w_push   = sb.st_we & ~w_full & ~sb.prmiss;
    // A commit with nothing speculative has no entry to mark and is dropped.
    assign w_commit = sb.stcommit & (r_ccnt != r_cnt);
    assign w_pop    = (r_state == ST_REQ) & sb.mem_ack;

    // ------------------------------------------------------------------
    // Pointer / counter next-state
    // ------------------------------------------------------------------
    assign w_head_next = r_head + SB_SEL'(w_pop);
    assign w_ccnt_next = r_ccnt + c_cnt_w'(w_commit) - c_cnt_w'(w_pop);

    // On a flush only the committed run (after this cycle's commit and pop)
    // survives, so tail is pulled back to sit right behind it. A committed
    // count equal to SB_DEPTH wraps tail onto head, which is correct.
    assign w_cnt_next  = sb.prmiss ? w_ccnt_next
                                   : (r_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop));
    assign w_tail_next = sb.prmiss ? (w_head_next + w_ccnt_next[SB_SEL-1:0])
                                   : (r_tail + SB_SEL'(w_push));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
            r_ccnt  <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_cnt   <= w_cnt_next;
            r_ccnt  <= w_ccnt_next;
            r_state <= w_state_next;
        end
    end

    // Entry payload carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= sb.st_addr;
            r_data[r_tail] <= sb.st_data;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ccnt != '0) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_mem_we = 1'b1;
                if (sb.mem_ack) begin
                    // Keep streaming while another committed entry remains
                    // behind the one being popped.
                    if (r_ccnt > c_cnt_w'(1)) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The head entry cannot be overwritten while requested. A push only
    // writes tail, and tail differs from head whenever 0 < cnt < SB_DEPTH.
    assign sb.mem_we   = w_mem_we;
    assign sb.mem_addr = r_addr[r_head];
    assign sb.mem_data = r_data[r_head];

    // ------------------------------------------------------------------
    // Store-to-load forwarding
    // ------------------------------------------------------------------
`ifdef STORE_BUFFER_FWD_EN
    // Index k walks entries by age: k=0 is head (oldest), higher k is
    // younger. Valid entries are those with age below cnt.
    logic [SB_DEPTH-1:0] w_age_match;
    logic [SB_SEL-1:0]   w_age_slot [SB_DEPTH];
    logic                w_ld_hit;
    logic [DATA_LEN-1:0] w_ld_data;
    wire                 w_unused_ld_lsb = ^sb.ld_addr[1:0];

    for (genvar k = 0; k < SB_DEPTH; k++) begin : g_age
        assign w_age_slot[k]  = r_head + SB_SEL'(k);
        assign w_age_match[k] = (c_cnt_w'(k) < r_cnt) &&
                                (r_addr[w_age_slot[k]][ADDR_LEN-1:2] ==
                                 sb.ld_addr[ADDR_LEN-1:2]);
    end

    // Later (younger) matches override earlier ones.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (w_age_match[i]) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_data[w_age_slot[i]];
            end
        end
    end

    assign sb.ld_hit  = w_ld_hit;
    assign sb.ld_data = w_ld_data;
`else
    // No forwarding: loads must wait for sb_empty before executing.
    wire w_unused_ld_addr = ^sb.ld_addr;

    assign sb.ld_hit  = 1'b0;
    assign sb.ld_data = '0;
`endif

    // ------------------------------------------------------------------
    // Protocol check: the reorder buffer must not commit a store that has
    // not been executed into the buffer.
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_commit_has_spec: assert property (
        @(posedge clk) disable iff (!reset)
        sb.stcommit |-> (r_ccnt != r_cnt)
    ) else $error("store_buffer: stcommit with no speculative entry");
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Scoreboard bench for store_buffer. Stimulus queues each
//                expected memory write. A negedge monitor pops and compares
//                on every mem_we/mem_ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_buffer;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    store_buffer_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) sb_if ();

    store_buffer #(
        .SB_DEPTH (4),
        .SB_SEL   (2),
        .ADDR_LEN (AW),
        .DATA_LEN (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q [$];
    txn_t mon_e;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   n_drained  = 0;
    int   we_run     = 0;
    int   we_max_run = 0;
    logic ack_level  = 1'b0;
    logic ack_rand   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // ------------------------------------------------------------------
    // Monitor: scoreboard on drain handshakes, run length of mem_we
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset && sb_if.mem_we) we_run++;
        else                       we_run = 0;
        if (we_run > we_max_run) we_max_run = we_run;
        if (reset && sb_if.mem_we && sb_if.mem_ack) begin
            n_drained++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL drain_unexpected: got addr 0x%0h data 0x%0h, required no request",
                         sb_if.mem_addr, sb_if.mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("drain_addr", 64'(sb_if.mem_addr), 64'(mon_e.addr));
                chk("drain_data", 64'(sb_if.mem_data), 64'(mon_e.data));
            end
        end
    end

    // mem_ack driver, offset from the stimulus update to avoid races.
    initial begin
        sb_if.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sb_if.mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : ack_level;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb_if.st_we   = 1'b1;
        sb_if.st_addr = a;
        sb_if.st_data = d;
        tick();
        sb_if.st_we   = 1'b0;
    endtask

    task automatic commit_n(input int n);
        repeat (n) begin
            sb_if.stcommit = 1'b1;
            tick();
        end
        sb_if.stcommit = 1'b0;
    endtask

    task automatic expect_drain(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_empty(input string name, input int budget);
        int i = 0;
        while (!sb_if.sb_empty && i < budget) begin
            tick();
            i++;
        end
        chk(name, 64'(sb_if.sb_empty), 64'(1));
    endtask

    task automatic wait_we(input string name, input int budget);
        int i = 0;
        while (!sb_if.mem_we && i < budget) begin
            tick();
            i++;
        end
        chk(name, 64'(sb_if.mem_we), 64'(1));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        sb_if.st_we    = 1'b0;
        sb_if.st_addr  = '0;
        sb_if.st_data  = '0;
        sb_if.stcommit = 1'b0;
        sb_if.prmiss   = 1'b0;
        sb_if.ld_addr  = '0;

        // Reset state
        repeat (3) tick();
        chk("rst0_mem_we", 64'(sb_if.mem_we),   64'(0));
        chk("rst0_empty",  64'(sb_if.sb_empty), 64'(1));
        chk("rst0_full",   64'(sb_if.sb_full),  64'(0));
        chk("rst0_ld_hit", 64'(sb_if.ld_hit),   64'(0));
        reset = 1'b1;
        tick();

        // Fill and drain with mem_ack tied high
        ack_level = 1'b1;
        tick();
        we_max_run = 0;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("fill_full",      64'(sb_if.sb_full),  64'(1));
        chk("fill_not_empty", 64'(sb_if.sb_empty), 64'(0));
        push(32'h1F0, 32'hEE);
        chk("fill_full_hold", 64'(sb_if.sb_full), 64'(1));
        for (int i = 0; i < 4; i++) expect_drain(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        commit_n(4);
        wait_empty("fill_empty", 50);
        tick();
        tick();
        chk("fill_run",     64'(we_max_run), 64'(4));
        chk("fill_drained", 64'(n_drained),  64'(4));

        // Flush: one committed, two speculative discarded
        push(32'h100, 32'hB0);
        push(32'h104, 32'hB1);
        push(32'h108, 32'hB2);
        expect_drain(32'h100, 32'hB0);
        commit_n(1);
        sb_if.prmiss = 1'b1;
        tick();
        sb_if.prmiss = 1'b0;
        chk("flush_tail",  64'(dut.r_tail),     64'(1));
        chk("flush_cnt1",  64'(dut.r_cnt),      64'(1));
        chk("flush_empty0", 64'(sb_if.sb_empty), 64'(0));
        wait_empty("flush_empty", 20);
        chk("flush_cnt0",  64'(dut.r_cnt),      64'(0));
        push(32'h140, 32'hC0);
        chk("flush_slot1", 64'(dut.r_addr[1]),  64'(32'h140));
        expect_drain(32'h140, 32'hC0);
        commit_n(1);
        wait_empty("flush_next_empty", 20);

        // Ack stall: request must hold while push/commit still land
        ack_level = 1'b0;
        tick();
        tick();
        push(32'h300, 32'hD0);
        expect_drain(32'h300, 32'hD0);
        commit_n(1);
        wait_we("stall_req", 20);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                sb_if.st_we   = 1'b1;
                sb_if.st_addr = 32'h304;
                sb_if.st_data = 32'hD1;
            end
            if (i == 1) begin
                sb_if.stcommit = 1'b1;
                expect_drain(32'h304, 32'hD1);
            end
            @(negedge clk);
            chk("stall_addr", 64'(sb_if.mem_addr), 64'(32'h300));
            chk("stall_data", 64'(sb_if.mem_data), 64'(32'hD0));
            tick();
            sb_if.st_we    = 1'b0;
            sb_if.stcommit = 1'b0;
        end
        chk("stall_cnt",  64'(dut.r_cnt),  64'(2));
        chk("stall_ccnt", 64'(dut.r_ccnt), 64'(2));
        ack_level = 1'b1;
        wait_empty("stall_empty", 30);

        // Wrap-around: 10 rounds of 3 with random ack gaps
        ack_rand = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                push(32'h1000 + 32'(4 * (3 * r + k)), 32'h5000 + 32'(3 * r + k));
                expect_drain(32'h1000 + 32'(4 * (3 * r + k)), 32'h5000 + 32'(3 * r + k));
            end
            commit_n(3);
            wait_empty("wrap_empty", 300);
        end
        ack_rand = 1'b0;
        tick();
        chk("wrap_drained", 64'(n_drained), 64'(38));

        // Forwarding probe
        ack_level = 1'b0;
        tick();
        tick();
        push(32'h200, 32'h11);
        push(32'h200, 32'h22);
        sb_if.ld_addr = 32'h202;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd_hit",  64'(sb_if.ld_hit),  64'(1));
        chk("fwd_data", 64'(sb_if.ld_data), 64'(32'h22));
        sb_if.ld_addr = 32'h204;
        #1;
        chk("fwd_miss", 64'(sb_if.ld_hit), 64'(0));
        sb_if.ld_addr = 32'h300;
        #1;
        chk("fwd_stale_miss", 64'(sb_if.ld_hit), 64'(0));
`else
        chk("nofwd_hit",  64'(sb_if.ld_hit),  64'(0));
        chk("nofwd_data", 64'(sb_if.ld_data), 64'(0));
`endif
        expect_drain(32'h200, 32'h11);
        expect_drain(32'h200, 32'h22);
        commit_n(2);
        ack_level = 1'b1;
        wait_empty("fwd_empty", 30);

        // Asynchronous reset mid-drain with two committed entries
        ack_level = 1'b0;
        tick();
        tick();
        push(32'h400, 32'hE0);
        push(32'h404, 32'hE1);
        commit_n(2);
        wait_we("rst_req", 20);
        chk("rst_ccnt2", 64'(dut.r_ccnt), 64'(2));
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_we",    64'(sb_if.mem_we),   64'(0));
        chk("rst_async_empty", 64'(sb_if.sb_empty), 64'(1));
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_we",    64'(sb_if.mem_we),   64'(0));
        chk("rst_empty", 64'(sb_if.sb_empty), 64'(1));
        chk("rst_full",  64'(sb_if.sb_full),  64'(0));
        chk("rst_cnt",   64'(dut.r_cnt),      64'(0));
        tick();
        @(negedge clk);
        chk("rst_idle_we", 64'(sb_if.mem_we), 64'(0));

        // Final scoreboard accounting
        tick();
        chk("queue_empty",   64'(exp_q.size()), 64'(0));
        chk("total_drained", 64'(n_drained),    64'(40));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
